data_mem_responder: RTL

//  Responder end of the core's data-memory request interface: consumes memRead/memWrite

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/dmem_array.sv | 31 +++
 rtl/data_mem_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the core and its memory-side blocks.
//   - instruction opcode constants used by the main controller
//   - data-memory responder state encodings
//   - WORD_OFF: number of byte-offset bits below the word index
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_t;

  localparam int WORD_OFF = 2;

endpackage

// File: rtl/dmem_array.sv
// Word storage behind the data-memory responder.
// Synchronous write, asynchronous (combinational) read. Contents are not reset.
// Ports:
//   clk    in   1       write clock
//   we     in   1       write enable
//   waddr  in   IDX_W   write word index
//   wdata  in   DATA_W  write data
//   raddr  in   IDX_W   read word index
//   rdata  out  DATA_W  read data for raddr
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the core's data-memory request interface.
// Accepts a load or store, waits WAIT_CYC cycles, then gives a one-cycle
// memReady strobe (with err if the request was illegal). busy stalls the core
// from the accept cycle through the memReady cycle.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   MEM_IDLE | waiting for memRead/memWrite; accepts on request
//   MEM_WAIT | counting down wait states, inputs ignored
//   MEM_RESP | memReady high; store commits at end of this cycle
//
// Ports:
//   clk        in   1       system clock
//   rst_n      in   1       asynchronous active-low reset
//   memRead    in   1       load request (level)
//   memWrite   in   1       store request (level)
//   address    in   ADDR_W  byte address
//   writeData  in   DATA_W  store data
//   readData   out  DATA_W  load data, nonzero only with memReady
//   memReady   out  1       one-cycle completion strobe
//   err        out  1       request rejected (only with memReady)
//   busy       out  1       accept cycle through memReady cycle
module data_mem_responder
  import riscv_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              memReady,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int WIDX_W = ADDR_W - WORD_OFF;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  mem_state_t        state;
  logic [3:0]        cnt;
  logic              op_read;
  logic              op_write;
  logic              bad_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;

  logic              req;
  logic              bad_req;
  logic [WIDX_W-1:0] word_idx;
  logic [IDX_W-1:0]  raddr;
  logic [DATA_W-1:0] rdata;
  logic              we;
  logic              resp_bad;
  logic              resp_rd;

  assign req      = memRead | memWrite;
  assign word_idx = address[ADDR_W-1:WORD_OFF];
  assign bad_req  = (address[WORD_OFF-1:0] != '0)
                 || (word_idx >= WIDX_W'(DEPTH))
                 || (memRead && memWrite);

  assign busy = (state != MEM_IDLE) || req;

  // With WAIT_CYC=0 the response is registered straight from IDLE, before
  // the latched copies exist, so the read port and response qualifiers
  // follow the live inputs while idle and the latched values otherwise.
  assign raddr    = (state == MEM_IDLE) ? word_idx[IDX_W-1:0] : idx_q;
  assign resp_bad = (state == MEM_IDLE) ? bad_req : bad_q;
  assign resp_rd  = (state == MEM_IDLE) ? memRead : op_read;

  // Gated by state so a reset during WAIT/RESP can never commit the store.
  assign we = (state == MEM_RESP) && op_write && !bad_q;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MEM_IDLE;
      cnt      <= '0;
      op_read  <= 1'b0;
      op_write <= 1'b0;
      bad_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      readData <= '0;
      memReady <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (req) begin
            op_read  <= memRead;
            op_write <= memWrite;
            bad_q    <= bad_req;
            idx_q    <= word_idx[IDX_W-1:0];
            wdata_q  <= writeData;
            cnt      <= WAIT_LD;
            if (WAIT_CYC == 0) begin
              state    <= MEM_RESP;
              memReady <= 1'b1;
              err      <= resp_bad;
              readData <= (resp_rd && !resp_bad) ? rdata : '0;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (cnt <= 4'd1) begin
            state    <= MEM_RESP;
            memReady <= 1'b1;
            err      <= resp_bad;
            readData <= (resp_rd && !resp_bad) ? rdata : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        MEM_RESP: begin
          state    <= MEM_IDLE;
          memReady <= 1'b0;
          err      <= 1'b0;
          readData <= '0;
        end
        default: begin
          state    <= MEM_IDLE;
          memReady <= 1'b0;
          err      <= 1'b0;
          readData <= '0;
        end
      endcase
    end
  end

endmodule
